// File: rtl/acc_alu_pkg.sv
// Shared definitions for the accumulator ALU: opcode constants (also used by the
// CPU decoder) and the multiply FSM state encoding.
package acc_alu_pkg;
  typedef logic [3:0] op_t;

  localparam op_t OP_NOP = 4'd0;
  localparam op_t OP_LD  = 4'd1;
  localparam op_t OP_ADD = 4'd2;
  localparam op_t OP_SUB = 4'd3;
  localparam op_t OP_AND = 4'd4;
  localparam op_t OP_OR  = 4'd5;
  localparam op_t OP_XOR = 4'd6;
  localparam op_t OP_NOT = 4'd7;
  localparam op_t OP_SHL = 4'd8;
  localparam op_t OP_SHR = 4'd9;
  localparam op_t OP_ADC = 4'd10;
  localparam op_t OP_CLC = 4'd11;
  localparam op_t OP_MUL = 4'd12;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/acc_alu_if.sv
// Command/result bundle between the CPU datapath and the accumulator ALU.
interface acc_alu_if #(parameter int WIDTH = 8) ();
  import acc_alu_pkg::*;

  logic             en;
  op_t              op;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic             z;
  logic             busy;

  modport master (output en, op, in, input acc, c, z, busy);
  modport slave  (input en, op, in, output acc, c, z, busy);
endinterface

// File: rtl/acc_alu_mul_seq.sv
// Sequential shift-add multiplier, one partial product per clock. p/done present
// the final sum during the last busy cycle so the caller commits it on that edge.
module mul_seq
  import acc_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
  logic [WIDTH-1:0]   mplier;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)       state_nxt = ST_MUL;
      ST_MUL:  if (cnt == LAST) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy     = (state == ST_MUL);
  assign done     = busy && (cnt == LAST);
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign p        = prod_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && !busy) begin
      cnt    <= '0;
      prod   <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      prod   <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= done ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/acc_alu.sv
// Accumulator ALU: ACC plus carry/zero flags, single-cycle ops on ACC and IN.
// Define ACC_ALU_MUL_EN to add the sequential multiply on OP_MUL.
module acc_alu
  import acc_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  acc_alu_if.slave    bus
);
  logic [WIDTH-1:0]   acc_q, acc_nxt;
  logic               c_q, z_q, c_nxt, z_upd;
  logic [WIDTH:0]     sum;
  logic               exec, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_p;

  // Commands arriving while a multiply runs are dropped, not queued.
  assign exec = bus.en && !mul_busy;

  always_comb begin
    acc_nxt = acc_q;
    c_nxt   = c_q;
    z_upd   = 1'b0;
    sum     = '0;
    case (bus.op)
      OP_LD:  begin acc_nxt = bus.in; z_upd = 1'b1; end
      OP_ADD: begin
        sum = {1'b0, acc_q} + {1'b0, bus.in};
        {c_nxt, acc_nxt} = sum; z_upd = 1'b1;
      end
      OP_SUB: begin
        // Bit WIDTH of the widened difference is the borrow.
        sum = {1'b0, acc_q} - {1'b0, bus.in};
        {c_nxt, acc_nxt} = sum; z_upd = 1'b1;
      end
      OP_ADC: begin
        sum = {1'b0, acc_q} + {1'b0, bus.in} + {{WIDTH{1'b0}}, c_q};
        {c_nxt, acc_nxt} = sum; z_upd = 1'b1;
      end
      OP_AND: begin acc_nxt = acc_q & bus.in; c_nxt = 1'b0; z_upd = 1'b1; end
      OP_OR:  begin acc_nxt = acc_q | bus.in; c_nxt = 1'b0; z_upd = 1'b1; end
      OP_XOR: begin acc_nxt = acc_q ^ bus.in; c_nxt = 1'b0; z_upd = 1'b1; end
      OP_NOT: begin acc_nxt = ~acc_q;         c_nxt = 1'b0; z_upd = 1'b1; end
      OP_SHL: begin acc_nxt = {acc_q[WIDTH-2:0], 1'b0}; c_nxt = acc_q[WIDTH-1]; z_upd = 1'b1; end
      OP_SHR: begin acc_nxt = {1'b0, acc_q[WIDTH-1:1]}; c_nxt = acc_q[0];       z_upd = 1'b1; end
      OP_CLC: c_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b1;
    end else if (mul_done) begin
      acc_q <= mul_p[WIDTH-1:0];
      c_q   <= |mul_p[2*WIDTH-1:WIDTH];
      z_q   <= (mul_p[WIDTH-1:0] == '0);
    end else if (exec) begin
      acc_q <= acc_nxt;
      c_q   <= c_nxt;
      if (z_upd) z_q <= (acc_nxt == '0);
    end
  end

`ifdef ACC_ALU_MUL_EN
  logic mul_start;
  assign mul_start = exec && (bus.op == OP_MUL);

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (acc_q),
    .b     (bus.in),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );
`else
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_p    = '0;
`endif

  assign bus.acc  = acc_q;
  assign bus.c    = c_q;
  assign bus.z    = z_q;
  assign bus.busy = mul_busy;
endmodule
